// File: rtl/lights_out_pkg.sv
// lights_out_pkg
// Shared definitions for the Lights Out game sequencer:
//   - default board dimensions
//   - LFSR feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting Galois form)
//   - FSM state enum and toggle-slot enum
//   - cell_idx(): flattened board bit index, row*cols + col
package lights_out_pkg;

  localparam int DEF_ROWS = 5;
  localparam int DEF_COLS = 5;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PICK,
    ST_APPLY,
    ST_CHECK,
    ST_WON
  } state_t;

  // Order of the single-cell toggles that make up one move
  typedef enum logic [2:0] {
    SL_CENTRE,
    SL_UP,
    SL_DOWN,
    SL_LEFT,
    SL_RIGHT
  } slot_t;

  function automatic int cell_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/lights_out_lfsr.sv
// lights_out_lfsr
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) used to pick scramble targets.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low reset, loads SEED
//   ena   in   advance one step per cycle while high
//   lfsr  out  current register value
module lights_out_lfsr
  import lights_out_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (ena) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/lights_out_game_ctrl.sv
// lights_out_game_ctrl
// Game sequencer: owns the board register and cursor, applies each press as
// five timed single-cell toggles (centre, up, down, left, right), scrambles new
// games from an LFSR, counts user moves and flags the solved state.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ena                  low freezes all state and ignores inputs
//   btn_up/down/left/right  cursor move pulses (wrap-around)
//   btn_sel              press the cell under the cursor
//   new_game             clear and scramble
//   board_o              cell state, bit row*COLS+col, 1 = lit
//   cursor_row/col       cursor position
//   busy                 move or scramble in progress
//   solved               last user move left the board dark
//   move_count           user moves since new game, saturating at 255
module lights_out_game_ctrl
  import lights_out_pkg::*;
#(
  parameter int          ROWS           = DEF_ROWS,
  parameter int          COLS           = DEF_COLS,
  parameter int          SCRAMBLE_MOVES = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_sel,
  input  logic                 new_game,
  output logic [ROWS*COLS-1:0] board_o,
  output logic [2:0]           cursor_row,
  output logic [2:0]           cursor_col,
  output logic                 busy,
  output logic                 solved,
  output logic [7:0]           move_count
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);

  state_t           state;
  slot_t            slot;
  logic             src_user;
  logic [2:0]       tgt_row;
  logic [2:0]       tgt_col;
  logic [7:0]       remaining;
  logic [15:0]      lfsr;
  logic             lfsr_unused;
  logic [CELLS-1:0] tog_mask;
  int               nbr_row;
  int               nbr_col;

  lights_out_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .lfsr (lfsr)
  );

  // Only the low byte feeds target selection
  assign lfsr_unused = ^lfsr[15:8];

  // Cell addressed by the current slot; off-board neighbours produce an
  // empty mask so the slot still costs its cycle but writes nothing.
  always_comb begin
    nbr_row  = int'(tgt_row);
    nbr_col  = int'(tgt_col);
    tog_mask = '0;
    case (slot)
      SL_UP:    nbr_row = nbr_row - 1;
      SL_DOWN:  nbr_row = nbr_row + 1;
      SL_LEFT:  nbr_col = nbr_col - 1;
      SL_RIGHT: nbr_col = nbr_col + 1;
      default:  ;
    endcase
    if (state == ST_APPLY && nbr_row >= 0 && nbr_row < ROWS &&
        nbr_col >= 0 && nbr_col < COLS) begin
      tog_mask[IDX_W'(cell_idx(nbr_row, nbr_col, COLS))] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      slot       <= SL_CENTRE;
      src_user   <= 1'b0;
      tgt_row    <= 3'd0;
      tgt_col    <= 3'd0;
      remaining  <= 8'd0;
      board_o    <= '0;
      cursor_row <= 3'(ROWS / 2);
      cursor_col <= 3'(COLS / 2);
      busy       <= 1'b0;
      solved     <= 1'b0;
      move_count <= 8'd0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          // Priority: new_game > btn_sel > up > down > left > right
          if (new_game) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
          end else if (btn_sel) begin
            tgt_row  <= cursor_row;
            tgt_col  <= cursor_col;
            src_user <= 1'b1;
            slot     <= SL_CENTRE;
            state    <= ST_APPLY;
            busy     <= 1'b1;
          end else if (btn_up) begin
            cursor_row <= (cursor_row == 3'd0) ? 3'(ROWS - 1) : cursor_row - 3'd1;
          end else if (btn_down) begin
            cursor_row <= (cursor_row == 3'(ROWS - 1)) ? 3'd0 : cursor_row + 3'd1;
          end else if (btn_left) begin
            cursor_col <= (cursor_col == 3'd0) ? 3'(COLS - 1) : cursor_col - 3'd1;
          end else if (btn_right) begin
            cursor_col <= (cursor_col == 3'(COLS - 1)) ? 3'd0 : cursor_col + 3'd1;
          end
        end
        ST_CLEAR: begin
          board_o    <= '0;
          move_count <= 8'd0;
          solved     <= 1'b0;
          remaining  <= 8'(SCRAMBLE_MOVES);
          state      <= ST_PICK;
        end
        ST_PICK: begin
          tgt_row  <= 3'(int'(lfsr[3:0]) % ROWS);
          tgt_col  <= 3'(int'(lfsr[7:4]) % COLS);
          src_user <= 1'b0;
          slot     <= SL_CENTRE;
          state    <= ST_APPLY;
        end
        ST_APPLY: begin
          board_o <= board_o ^ tog_mask;
          if (slot == SL_RIGHT) begin
            state <= ST_CHECK;
          end else begin
            slot <= slot_t'(slot + 3'd1);
          end
        end
        ST_CHECK: begin
          if (src_user) begin
            if (move_count != 8'hFF) begin
              move_count <= move_count + 8'd1;
            end
            busy <= 1'b0;
            if (board_o == '0) begin
              solved <= 1'b1;
              state  <= ST_WON;
            end else begin
              state <= ST_IDLE;
            end
          end else if (remaining > 8'd1) begin
            remaining <= remaining - 8'd1;
            state     <= ST_PICK;
          end else begin
            // Scramble budget spent: a dark board earns extra random presses
            remaining <= 8'd0;
            if (board_o != '0) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_PICK;
            end
          end
        end
        ST_WON: begin
          if (new_game) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lights_out_game_ctrl.sv
// Self-checking bench for lights_out_game_ctrl: directed scenarios followed by
// randomized operations, all compared against a board/cursor reference model.
module tb_lights_out_game_ctrl;

  localparam int          ROWS  = 5;
  localparam int          COLS  = 5;
  localparam int          SCR   = 8;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          CELLS = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b1;
  logic             btn_up = 1'b0;
  logic             btn_down = 1'b0;
  logic             btn_left = 1'b0;
  logic             btn_right = 1'b0;
  logic             btn_sel = 1'b0;
  logic             new_game = 1'b0;
  logic [CELLS-1:0] board_o;
  logic [2:0]       cursor_row;
  logic [2:0]       cursor_col;
  logic             busy;
  logic             solved;
  logic [7:0]       move_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [CELLS-1:0] m_board;
  int               m_row;
  int               m_col;
  int               m_moves;
  bit               m_solved;
  bit               m_won;
  logic [15:0]      m_lfsr;

  lights_out_game_ctrl #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .SCRAMBLE_MOVES(SCR),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_sel   (btn_sel),
    .new_game  (new_game),
    .board_o   (board_o),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .busy      (busy),
    .solved    (solved),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = lfsr_step(r);
    return r;
  endfunction

  // Lights Out press: toggle the first nslots cells of centre, up, down, left, right
  function automatic logic [CELLS-1:0] press(input logic [CELLS-1:0] b, input int r,
                                             input int c, input int nslots);
    int dr[5] = '{0, -1, 1, 0, 0};
    int dc[5] = '{0, 0, 0, -1, 1};
    logic [CELLS-1:0] res;
    res = b;
    for (int k = 0; k < nslots; k++) begin
      int rr;
      int cc;
      rr = r + dr[k];
      cc = c + dc[k];
      if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) res[rr * COLS + cc] = ~res[rr * COLS + cc];
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (ena && rst_n) m_lfsr = lfsr_step(m_lfsr);
    #1;
  endtask

  task automatic model_reset();
    m_board  = '0;
    m_row    = ROWS / 2;
    m_col    = COLS / 2;
    m_moves  = 0;
    m_solved = 1'b0;
    m_won    = 1'b0;
    m_lfsr   = SEED;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_board"}, board_o, m_board);
    check_val({tag, "_row"}, cursor_row, m_row);
    check_val({tag, "_col"}, cursor_col, m_col);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_solved"}, solved, m_solved);
    check_val({tag, "_moves"}, move_count, m_moves);
  endtask

  // Counts busy cycles, starting with the one already observed
  task automatic wait_idle(output int cnt);
    int guard;
    cnt   = 1;
    guard = 0;
    tick();
    while (busy && guard < 3000) begin
      cnt++;
      guard++;
      tick();
    end
    if (busy) check_val("busy_timeout", busy, 0);
  endtask

  task automatic do_cursor(input int dir);
    case (dir)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_left = 1'b1;
      default: btn_right = 1'b1;
    endcase
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    if (!m_won) begin
      case (dir)
        0: m_row = (m_row + ROWS - 1) % ROWS;
        1: m_row = (m_row + 1) % ROWS;
        2: m_col = (m_col + COLS - 1) % COLS;
        default: m_col = (m_col + 1) % COLS;
      endcase
    end
    check_val("cursor_row", cursor_row, m_row);
    check_val("cursor_col", cursor_col, m_col);
  endtask

  task automatic do_sel(input bit with_up, input bit up_busy);
    int cnt;
    btn_sel = 1'b1;
    btn_up  = with_up;
    tick();
    btn_sel = 1'b0;
    btn_up  = 1'b0;
    if (m_won) begin
      check_all("won_sel");
      return;
    end
    check_val("sel_busy", busy, 1);
    if (up_busy) begin
      btn_up = 1'b1;
      tick();
      btn_up = 1'b0;
      check_val("sel_busy2", busy, 1);
    end
    wait_idle(cnt);
    if (up_busy) cnt++;
    m_board = press(m_board, m_row, m_col, 5);
    if (m_moves < 255) m_moves++;
    if (m_board == '0) begin
      m_solved = 1'b1;
      m_won    = 1'b1;
    end
    check_val("sel_cycles", cnt, 6);
    check_all("sel");
  endtask

  task automatic do_new_game(input bit stray);
    logic [15:0] v0;
    logic [15:0] v;
    int k;
    int cnt;
    v0      = m_lfsr;
    m_board = '0;
    k       = 0;
    while (k < 64) begin
      v = lfsr_adv(v0, 2 + 7 * k);
      m_board = press(m_board, int'(v[3:0]) % ROWS, int'(v[7:4]) % COLS, 5);
      k++;
      if (k >= SCR && m_board != '0) break;
    end
    m_moves  = 0;
    m_solved = 1'b0;
    m_won    = 1'b0;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check_val("ng_busy", busy, 1);
    if (stray) begin
      btn_sel  = 1'b1;
      btn_left = 1'b1;
      new_game = 1'b1;
      tick();
      btn_sel  = 1'b0;
      btn_left = 1'b0;
      new_game = 1'b0;
    end
    wait_idle(cnt);
    if (stray) cnt++;
    check_val("ng_cycles", cnt, 1 + 7 * k);
    check_val("ng_nonzero", board_o != '0, 1);
    check_all("ng");
  endtask

  task automatic do_freeze();
    int cnt;
    int r;
    int c;
    r = m_row;
    c = m_col;
    btn_sel = 1'b1;
    tick();
    btn_sel = 1'b0;
    tick();
    tick();
    ena      = 1'b0;
    btn_left = 1'b1;
    repeat (10) tick();
    btn_left = 1'b0;
    check_val("frz_board", board_o, press(m_board, r, c, 2));
    check_val("frz_busy", busy, 1);
    check_val("frz_col", cursor_col, m_col);
    ena = 1'b1;
    wait_idle(cnt);
    check_val("frz_remaining", cnt, 4);
    m_board = press(m_board, r, c, 5);
    if (m_moves < 255) m_moves++;
    if (m_board == '0) begin
      m_solved = 1'b1;
      m_won    = 1'b1;
    end
    check_all("frz");
  endtask

  initial begin
    int op;
    do_reset();
    check_all("reset");

    // Press at centre, then again to solve
    do_sel(1'b0, 1'b0);
    check_val("tp1_board", board_o, 25'h23880);
    do_sel(1'b0, 1'b0);
    check_val("tp2_solved", solved, 1);
    do_sel(1'b0, 1'b0);
    do_cursor(2);

    // Corner press and wrap-around
    do_reset();
    do_cursor(2);
    do_cursor(2);
    do_cursor(0);
    do_cursor(0);
    do_sel(1'b0, 1'b0);
    check_val("tp3_board", board_o, 25'h23);
    do_cursor(2);
    check_val("tp3_wrap", cursor_col, 4);

    // Same-cycle priority and drop-while-busy
    do_reset();
    do_sel(1'b1, 1'b1);

    // Scramble with stray inputs while busy
    do_new_game(1'b1);

    // Clock-enable freeze mid-move
    do_freeze();

    // Asynchronous reset in the middle of a scramble
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    repeat (20) tick();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    tick();
    rst_n = 1'b1;
    do_sel(1'b0, 1'b0);
    check_val("post_rst_board", board_o, 25'h23880);

    // Randomized operation mix
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 99);
      if (op < 50) do_cursor($urandom_range(0, 3));
      else if (op < 80) do_sel(1'b0, 1'($urandom_range(0, 1)));
      else if (op < 90) do_new_game(1'($urandom_range(0, 1)));
      else begin
        repeat ($urandom_range(1, 5)) tick();
        check_all("idle");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
